// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath constants and the state encoding of the sequential
// inverse SubBytes engine.
//   AES_STATE_W : width of a full AES state (128 bits)
//   AES_BYTE_W  : width of one state byte
//   AES_NBYTES  : number of bytes in a state
//   isb_state_t : IDLE / RUN / DONE states of inv_sub_bytes_seq
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } isb_state_t;

endpackage

// File: rtl/inv_sbox_LUT.sv
// ---------------------------------------------------------------------------
// inv_sbox_LUT
// Purely combinational AES inverse S-box (exact inverse of the forward
// S-box). Port names mirror the forward sbox_LUT so the two can be swapped.
//   byte_in   : input byte
//   inv_sbyte : inverse-substituted byte
// ---------------------------------------------------------------------------
module inv_sbox_LUT
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] byte_in,
    output logic [AES_BYTE_W-1:0] inv_sbyte
);

    always_comb begin
        inv_sbyte = 8'h00;
        case (byte_in)
            8'h00: inv_sbyte = 8'h52; 8'h01: inv_sbyte = 8'h09; 8'h02: inv_sbyte = 8'h6a; 8'h03: inv_sbyte = 8'hd5;
            8'h04: inv_sbyte = 8'h30; 8'h05: inv_sbyte = 8'h36; 8'h06: inv_sbyte = 8'ha5; 8'h07: inv_sbyte = 8'h38;
            8'h08: inv_sbyte = 8'hbf; 8'h09: inv_sbyte = 8'h40; 8'h0a: inv_sbyte = 8'ha3; 8'h0b: inv_sbyte = 8'h9e;
            8'h0c: inv_sbyte = 8'h81; 8'h0d: inv_sbyte = 8'hf3; 8'h0e: inv_sbyte = 8'hd7; 8'h0f: inv_sbyte = 8'hfb;
            8'h10: inv_sbyte = 8'h7c; 8'h11: inv_sbyte = 8'he3; 8'h12: inv_sbyte = 8'h39; 8'h13: inv_sbyte = 8'h82;
            8'h14: inv_sbyte = 8'h9b; 8'h15: inv_sbyte = 8'h2f; 8'h16: inv_sbyte = 8'hff; 8'h17: inv_sbyte = 8'h87;
            8'h18: inv_sbyte = 8'h34; 8'h19: inv_sbyte = 8'h8e; 8'h1a: inv_sbyte = 8'h43; 8'h1b: inv_sbyte = 8'h44;
            8'h1c: inv_sbyte = 8'hc4; 8'h1d: inv_sbyte = 8'hde; 8'h1e: inv_sbyte = 8'he9; 8'h1f: inv_sbyte = 8'hcb;
            8'h20: inv_sbyte = 8'h54; 8'h21: inv_sbyte = 8'h7b; 8'h22: inv_sbyte = 8'h94; 8'h23: inv_sbyte = 8'h32;
            8'h24: inv_sbyte = 8'ha6; 8'h25: inv_sbyte = 8'hc2; 8'h26: inv_sbyte = 8'h23; 8'h27: inv_sbyte = 8'h3d;
            8'h28: inv_sbyte = 8'hee; 8'h29: inv_sbyte = 8'h4c; 8'h2a: inv_sbyte = 8'h95; 8'h2b: inv_sbyte = 8'h0b;
            8'h2c: inv_sbyte = 8'h42; 8'h2d: inv_sbyte = 8'hfa; 8'h2e: inv_sbyte = 8'hc3; 8'h2f: inv_sbyte = 8'h4e;
            8'h30: inv_sbyte = 8'h08; 8'h31: inv_sbyte = 8'h2e; 8'h32: inv_sbyte = 8'ha1; 8'h33: inv_sbyte = 8'h66;
            8'h34: inv_sbyte = 8'h28; 8'h35: inv_sbyte = 8'hd9; 8'h36: inv_sbyte = 8'h24; 8'h37: inv_sbyte = 8'hb2;
            8'h38: inv_sbyte = 8'h76; 8'h39: inv_sbyte = 8'h5b; 8'h3a: inv_sbyte = 8'ha2; 8'h3b: inv_sbyte = 8'h49;
            8'h3c: inv_sbyte = 8'h6d; 8'h3d: inv_sbyte = 8'h8b; 8'h3e: inv_sbyte = 8'hd1; 8'h3f: inv_sbyte = 8'h25;
            8'h40: inv_sbyte = 8'h72; 8'h41: inv_sbyte = 8'hf8; 8'h42: inv_sbyte = 8'hf6; 8'h43: inv_sbyte = 8'h64;
            8'h44: inv_sbyte = 8'h86; 8'h45: inv_sbyte = 8'h68; 8'h46: inv_sbyte = 8'h98; 8'h47: inv_sbyte = 8'h16;
            8'h48: inv_sbyte = 8'hd4; 8'h49: inv_sbyte = 8'ha4; 8'h4a: inv_sbyte = 8'h5c; 8'h4b: inv_sbyte = 8'hcc;
            8'h4c: inv_sbyte = 8'h5d; 8'h4d: inv_sbyte = 8'h65; 8'h4e: inv_sbyte = 8'hb6; 8'h4f: inv_sbyte = 8'h92;
            8'h50: inv_sbyte = 8'h6c; 8'h51: inv_sbyte = 8'h70; 8'h52: inv_sbyte = 8'h48; 8'h53: inv_sbyte = 8'h50;
            8'h54: inv_sbyte = 8'hfd; 8'h55: inv_sbyte = 8'hed; 8'h56: inv_sbyte = 8'hb9; 8'h57: inv_sbyte = 8'hda;
            8'h58: inv_sbyte = 8'h5e; 8'h59: inv_sbyte = 8'h15; 8'h5a: inv_sbyte = 8'h46; 8'h5b: inv_sbyte = 8'h57;
            8'h5c: inv_sbyte = 8'ha7; 8'h5d: inv_sbyte = 8'h8d; 8'h5e: inv_sbyte = 8'h9d; 8'h5f: inv_sbyte = 8'h84;
            8'h60: inv_sbyte = 8'h90; 8'h61: inv_sbyte = 8'hd8; 8'h62: inv_sbyte = 8'hab; 8'h63: inv_sbyte = 8'h00;
            8'h64: inv_sbyte = 8'h8c; 8'h65: inv_sbyte = 8'hbc; 8'h66: inv_sbyte = 8'hd3; 8'h67: inv_sbyte = 8'h0a;
            8'h68: inv_sbyte = 8'hf7; 8'h69: inv_sbyte = 8'he4; 8'h6a: inv_sbyte = 8'h58; 8'h6b: inv_sbyte = 8'h05;
            8'h6c: inv_sbyte = 8'hb8; 8'h6d: inv_sbyte = 8'hb3; 8'h6e: inv_sbyte = 8'h45; 8'h6f: inv_sbyte = 8'h06;
            8'h70: inv_sbyte = 8'hd0; 8'h71: inv_sbyte = 8'h2c; 8'h72: inv_sbyte = 8'h1e; 8'h73: inv_sbyte = 8'h8f;
            8'h74: inv_sbyte = 8'hca; 8'h75: inv_sbyte = 8'h3f; 8'h76: inv_sbyte = 8'h0f; 8'h77: inv_sbyte = 8'h02;
            8'h78: inv_sbyte = 8'hc1; 8'h79: inv_sbyte = 8'haf; 8'h7a: inv_sbyte = 8'hbd; 8'h7b: inv_sbyte = 8'h03;
            8'h7c: inv_sbyte = 8'h01; 8'h7d: inv_sbyte = 8'h13; 8'h7e: inv_sbyte = 8'h8a; 8'h7f: inv_sbyte = 8'h6b;
            8'h80: inv_sbyte = 8'h3a; 8'h81: inv_sbyte = 8'h91; 8'h82: inv_sbyte = 8'h11; 8'h83: inv_sbyte = 8'h41;
            8'h84: inv_sbyte = 8'h4f; 8'h85: inv_sbyte = 8'h67; 8'h86: inv_sbyte = 8'hdc; 8'h87: inv_sbyte = 8'hea;
            8'h88: inv_sbyte = 8'h97; 8'h89: inv_sbyte = 8'hf2; 8'h8a: inv_sbyte = 8'hcf; 8'h8b: inv_sbyte = 8'hce;
            8'h8c: inv_sbyte = 8'hf0; 8'h8d: inv_sbyte = 8'hb4; 8'h8e: inv_sbyte = 8'he6; 8'h8f: inv_sbyte = 8'h73;
            8'h90: inv_sbyte = 8'h96; 8'h91: inv_sbyte = 8'hac; 8'h92: inv_sbyte = 8'h74; 8'h93: inv_sbyte = 8'h22;
            8'h94: inv_sbyte = 8'he7; 8'h95: inv_sbyte = 8'had; 8'h96: inv_sbyte = 8'h35; 8'h97: inv_sbyte = 8'h85;
            8'h98: inv_sbyte = 8'he2; 8'h99: inv_sbyte = 8'hf9; 8'h9a: inv_sbyte = 8'h37; 8'h9b: inv_sbyte = 8'he8;
            8'h9c: inv_sbyte = 8'h1c; 8'h9d: inv_sbyte = 8'h75; 8'h9e: inv_sbyte = 8'hdf; 8'h9f: inv_sbyte = 8'h6e;
            8'ha0: inv_sbyte = 8'h47; 8'ha1: inv_sbyte = 8'hf1; 8'ha2: inv_sbyte = 8'h1a; 8'ha3: inv_sbyte = 8'h71;
            8'ha4: inv_sbyte = 8'h1d; 8'ha5: inv_sbyte = 8'h29; 8'ha6: inv_sbyte = 8'hc5; 8'ha7: inv_sbyte = 8'h89;
            8'ha8: inv_sbyte = 8'h6f; 8'ha9: inv_sbyte = 8'hb7; 8'haa: inv_sbyte = 8'h62; 8'hab: inv_sbyte = 8'h0e;
            8'hac: inv_sbyte = 8'haa; 8'had: inv_sbyte = 8'h18; 8'hae: inv_sbyte = 8'hbe; 8'haf: inv_sbyte = 8'h1b;
            8'hb0: inv_sbyte = 8'hfc; 8'hb1: inv_sbyte = 8'h56; 8'hb2: inv_sbyte = 8'h3e; 8'hb3: inv_sbyte = 8'h4b;
            8'hb4: inv_sbyte = 8'hc6; 8'hb5: inv_sbyte = 8'hd2; 8'hb6: inv_sbyte = 8'h79; 8'hb7: inv_sbyte = 8'h20;
            8'hb8: inv_sbyte = 8'h9a; 8'hb9: inv_sbyte = 8'hdb; 8'hba: inv_sbyte = 8'hc0; 8'hbb: inv_sbyte = 8'hfe;
            8'hbc: inv_sbyte = 8'h78; 8'hbd: inv_sbyte = 8'hcd; 8'hbe: inv_sbyte = 8'h5a; 8'hbf: inv_sbyte = 8'hf4;
            8'hc0: inv_sbyte = 8'h1f; 8'hc1: inv_sbyte = 8'hdd; 8'hc2: inv_sbyte = 8'ha8; 8'hc3: inv_sbyte = 8'h33;
            8'hc4: inv_sbyte = 8'h88; 8'hc5: inv_sbyte = 8'h07; 8'hc6: inv_sbyte = 8'hc7; 8'hc7: inv_sbyte = 8'h31;
            8'hc8: inv_sbyte = 8'hb1; 8'hc9: inv_sbyte = 8'h12; 8'hca: inv_sbyte = 8'h10; 8'hcb: inv_sbyte = 8'h59;
            8'hcc: inv_sbyte = 8'h27; 8'hcd: inv_sbyte = 8'h80; 8'hce: inv_sbyte = 8'hec; 8'hcf: inv_sbyte = 8'h5f;
            8'hd0: inv_sbyte = 8'h60; 8'hd1: inv_sbyte = 8'h51; 8'hd2: inv_sbyte = 8'h7f; 8'hd3: inv_sbyte = 8'ha9;
            8'hd4: inv_sbyte = 8'h19; 8'hd5: inv_sbyte = 8'hb5; 8'hd6: inv_sbyte = 8'h4a; 8'hd7: inv_sbyte = 8'h0d;
            8'hd8: inv_sbyte = 8'h2d; 8'hd9: inv_sbyte = 8'he5; 8'hda: inv_sbyte = 8'h7a; 8'hdb: inv_sbyte = 8'h9f;
            8'hdc: inv_sbyte = 8'h93; 8'hdd: inv_sbyte = 8'hc9; 8'hde: inv_sbyte = 8'h9c; 8'hdf: inv_sbyte = 8'hef;
            8'he0: inv_sbyte = 8'ha0; 8'he1: inv_sbyte = 8'he0; 8'he2: inv_sbyte = 8'h3b; 8'he3: inv_sbyte = 8'h4d;
            8'he4: inv_sbyte = 8'hae; 8'he5: inv_sbyte = 8'h2a; 8'he6: inv_sbyte = 8'hf5; 8'he7: inv_sbyte = 8'hb0;
            8'he8: inv_sbyte = 8'hc8; 8'he9: inv_sbyte = 8'heb; 8'hea: inv_sbyte = 8'hbb; 8'heb: inv_sbyte = 8'h3c;
            8'hec: inv_sbyte = 8'h83; 8'hed: inv_sbyte = 8'h53; 8'hee: inv_sbyte = 8'h99; 8'hef: inv_sbyte = 8'h61;
            8'hf0: inv_sbyte = 8'h17; 8'hf1: inv_sbyte = 8'h2b; 8'hf2: inv_sbyte = 8'h04; 8'hf3: inv_sbyte = 8'h7e;
            8'hf4: inv_sbyte = 8'hba; 8'hf5: inv_sbyte = 8'h77; 8'hf6: inv_sbyte = 8'hd6; 8'hf7: inv_sbyte = 8'h26;
            8'hf8: inv_sbyte = 8'he1; 8'hf9: inv_sbyte = 8'h69; 8'hfa: inv_sbyte = 8'h14; 8'hfb: inv_sbyte = 8'h63;
            8'hfc: inv_sbyte = 8'h55; 8'hfd: inv_sbyte = 8'h21; 8'hfe: inv_sbyte = 8'h0c; 8'hff: inv_sbyte = 8'h7d;
            default: inv_sbyte = 8'h00;
        endcase
    end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// inv_sub_bytes_seq
// Sequential AES inverse SubBytes: substitutes LANES bytes of a 128-bit
// state per cycle, so one state takes NSTEPS = 16/LANES cycles in RUN.
// Byte k of a state is bits [127-8k -: 8] (byte 0 is the MSB byte).
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset
//   in_valid  : state_in is valid
//   in_ready  : block can accept a state (high only in IDLE)
//   state_in  : input state
//   out_valid : state_out holds a completed result (high only in DONE)
//   out_ready : downstream accepts the result
//   state_out : inverse-substituted state, driven from the working register
//   busy      : high while substituting (RUN)
// LANES must divide 16 (1, 2, 4, 8 or 16).
// ---------------------------------------------------------------------------
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] state_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] state_out,
    output logic                   busy
);

    localparam int NSTEPS = AES_NBYTES / LANES;
    localparam int STEP_W = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

    isb_state_t             state_q, state_d;
    logic [AES_STATE_W-1:0] work_q, work_d;
    logic [STEP_W-1:0]      step_q, step_d;

    logic [AES_BYTE_W-1:0]  lane_in  [LANES];
    logic [AES_BYTE_W-1:0]  lane_out [LANES];

    // The working register is the output register: in DONE it holds the
    // finished result, so state_out never depends on the LUT outputs.
    assign state_out = work_q;

    // Select the group of LANES bytes addressed by the current step. The
    // loops unroll to a constant-index mux, one input per step.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = '0;
            for (int s = 0; s < NSTEPS; s++) begin
                if (step_q == STEP_W'(s)) begin
                    lane_in[l] = work_q[AES_STATE_W-1-AES_BYTE_W*(s*LANES+l) -: AES_BYTE_W];
                end
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sbox_LUT u_inv_sbox (
            .byte_in   (lane_in[l]),
            .inv_sbyte (lane_out[l])
        );
    end

    // State, working register and step counter. Reset wins in every state,
    // so an in-flight state is dropped and never reported.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            step_q  <= step_d;
        end
    end

    // Next-state and handshake decode. Outputs depend only on the registered
    // state, so in_ready stays low in DONE even while out_ready is high.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        step_d    = step_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = state_in;
                    step_d  = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                // Write substituted bytes back into the positions they came from.
                for (int s = 0; s < NSTEPS; s++) begin
                    if (step_q == STEP_W'(s)) begin
                        for (int l = 0; l < LANES; l++) begin
                            work_d[AES_STATE_W-1-AES_BYTE_W*(s*LANES+l) -: AES_BYTE_W] = lane_out[l];
                        end
                    end
                end
                if (step_q == LAST_STEP) begin
                    step_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// ---------------------------------------------------------------------------
// tb_inv_sub_bytes_seq
// Drives three instances (LANES = 1, 4, 16) from shared inputs and compares
// them against a reference built from GF(2^8) arithmetic: the forward S-box
// is computed from the multiplicative inverse plus the affine map, and the
// inverse table is obtained by inverting that permutation.
// ---------------------------------------------------------------------------
module tb_inv_sub_bytes_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] state_in;
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [127:0] state_out [3];

    int nsteps_of [3] = '{16, 4, 1};

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_model [256];
    logic [7:0] inv_model [256];

    typedef struct packed {
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    inv_sub_bytes_seq #(.LANES(1)) u_dut_l1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
        .state_in(state_in), .out_valid(out_valid[0]), .out_ready(out_ready),
        .state_out(state_out[0]), .busy(busy[0])
    );

    inv_sub_bytes_seq #(.LANES(4)) u_dut_l4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
        .state_in(state_in), .out_valid(out_valid[1]), .out_ready(out_ready),
        .state_out(state_out[1]), .busy(busy[1])
    );

    inv_sub_bytes_seq #(.LANES(16)) u_dut_l16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]),
        .state_in(state_in), .out_valid(out_valid[2]), .out_ready(out_ready),
        .state_out(state_out[2]), .busy(busy[2])
    );

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_model();
        logic [7:0] a;
        logic [7:0] v;
        logic [7:0] s;
        for (int ai = 0; ai < 256; ai++) begin
            a = 8'(ai);
            v = 8'h00;
            if (ai != 0) begin
                for (int c = 1; c < 256; c++) begin
                    if (gmul(a, 8'(c)) == 8'h01) v = 8'(c);
                end
            end
            s = v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
            fwd_model[ai] = s;
            inv_model[s]  = a;
        end
    endtask

    function automatic logic [127:0] model_state(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[127-8*k -: 8] = inv_model[s[127-8*k -: 8]];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Wait for every instance to be idle, then hand over one state.
    task automatic apply_stimulus(input logic [127:0] s);
        int n;
        n = 0;
        while (!(in_ready[0] && in_ready[1] && in_ready[2]) && n < 60) begin
            tick();
            n++;
        end
        check("idle_wait", 128'(n < 60), 128'd1);
        state_in = s;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Follow the state through RUN with out_ready low, then release it.
    task automatic check_output(input string name, input logic [127:0] exp);
        int lat [3];
        bit ready_seen;
        bit busy_bad;
        lat = '{-1, -1, -1};
        ready_seen = 1'b0;
        busy_bad = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            for (int g = 0; g < 3; g++) begin
                if (lat[g] < 0 && out_valid[g]) lat[g] = n;
            end
            if (in_ready[1]) ready_seen = 1'b1;
            if (busy[1] != (n < nsteps_of[1])) busy_bad = 1'b1;
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
        end
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s_latency%0d", name, g), 128'(lat[g]), 128'(nsteps_of[g]));
            check($sformatf("%s_data%0d", name, g), state_out[g], exp);
            check($sformatf("%s_valid%0d", name, g), 128'(out_valid[g]), 128'd1);
        end
        check({name, "_inready_low"}, 128'(ready_seen), 128'd0);
        check({name, "_busy"}, 128'(busy_bad), 128'd0);
        out_ready = 1'b1;
        #1;
        for (int g = 0; g < 3; g++) check($sformatf("%s_nobypass%0d", name, g), 128'(in_ready[g]), 128'd0);
        tick();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s_release%0d", name, g), {126'd0, out_valid[g], in_ready[g]}, 128'd1);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] s;
        logic [127:0] a_st;
        logic [127:0] b_st;
        logic [127:0] held [3];
        int           acc [$];
        logic [127:0] res [$];
        bit           all_valid;
        int           n;

        build_model();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        state_in  = 128'h0;
        tick();
        tick();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("reset_flags%0d", g), {125'd0, in_ready[g], out_valid[g], busy[g]}, 128'd4);
            check($sformatf("reset_data%0d", g), state_out[g], 128'h0);
        end
        reset = 1'b0;
        tick();

        // Spec-given mappings as fixed vectors
        vecs[0] = '{din: {16{8'h63}}, dexp: 128'h0};
        vecs[1] = '{din: 128'h637c16ac8c7600636363636363636363,
                    dexp: 128'h0001ffaaf00f52000000000000000000};
        vecs[2] = '{din: 128'h0, dexp: {16{8'h52}}};
        vecs[3] = '{din: {16{8'h8c}}, dexp: {16{8'hf0}}};
        vecs[4] = '{din: {8{8'h7c, 8'h76}}, dexp: {8{8'h01, 8'h0f}}};
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].din);
            check_output($sformatf("table%0d", i), vecs[i].dexp);
        end

        // Backpressure: results hold for 10 cycles with out_ready low
        s = {$urandom(), $urandom(), $urandom(), $urandom()};
        apply_stimulus(s);
        n = 0;
        all_valid = 1'b0;
        while (!all_valid && n < 40) begin
            tick();
            n++;
            all_valid = out_valid[0] && out_valid[1] && out_valid[2];
        end
        check("bp_reach_done", 128'(all_valid), 128'd1);
        for (int g = 0; g < 3; g++) held[g] = state_out[g];
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int g = 0; g < 3; g++) begin
                check($sformatf("bp_hold%0d_%0d", g, c), {out_valid[g], state_out[g]}, {1'b1, held[g]});
            end
        end
        for (int g = 0; g < 3; g++) check($sformatf("bp_data%0d", g), held[g], model_state(s));
        out_ready = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) check($sformatf("bp_release%0d", g), {126'd0, out_valid[g], in_ready[g]}, 128'd1);
        out_ready = 1'b0;

        // Reset while the LANES=4 instance is at step 2
        apply_stimulus({16{8'h63}});
        tick();
        tick();
        reset = 1'b1;
        tick();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("midrst_flags%0d", g), {125'd0, in_ready[g], out_valid[g], busy[g]}, 128'd4);
            check($sformatf("midrst_data%0d", g), state_out[g], 128'h0);
        end
        reset = 1'b0;
        s = {$urandom(), $urandom(), $urandom(), $urandom()};
        apply_stimulus(s);
        check_output("after_reset", model_state(s));

        // Back-to-back on the LANES=4 instance with out_ready tied high
        a_st = {$urandom(), $urandom(), $urandom(), $urandom()};
        b_st = {$urandom(), $urandom(), $urandom(), $urandom()};
        state_in  = a_st;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && (acc.size() < 2 || res.size() < 2); c++) begin
            if (in_valid && in_ready[1]) acc.push_back(c);
            if (out_valid[1]) res.push_back(state_out[1]);
            tick();
            if (acc.size() == 1) state_in = b_st;
            if (acc.size() >= 2) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check("b2b_accepts", 128'(acc.size()), 128'd2);
        check("b2b_results", 128'(res.size()), 128'd2);
        if (acc.size() >= 2) check("b2b_gap", 128'(acc[1] - acc[0]), 128'(nsteps_of[1] + 2));
        if (res.size() >= 2) begin
            check("b2b_first", res[0], model_state(a_st));
            check("b2b_second", res[1], model_state(b_st));
        end
        n = 0;
        while (!(in_ready[0] && in_ready[1] && in_ready[2]) && n < 60) begin
            tick();
            n++;
        end
        check("b2b_drain", 128'(n < 60), 128'd1);
        out_ready = 1'b0;

        // Random states against the reference model
        for (int i = 0; i < 12; i++) begin
            s = {$urandom(), $urandom(), $urandom(), $urandom()};
            apply_stimulus(s);
            check_output($sformatf("rand%0d", i), model_state(s));
        end

        // Round trip over every byte value
        for (int b = 0; b < 256; b++) begin
            apply_stimulus({16{fwd_model[b]}});
            check_output($sformatf("rt%02h", b), {16{8'(b)}});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
